counter_hist: RTL and testbench

Parametrised up/down event counter with a snapshot history and rollback. It counts character/segment pulses in the string-recognition datapath. On every idle cycle it pushes its value into a DEPTH-deep history, and on request it reloads the count from a selectable history stage. Its gated output feeds the downstream comparator/display stage only while `hout` is asserted.

---
 rtl/counter_pkg.sv | 19 +
 rtl/hist_shreg.sv | 56 +++++
 rtl/counter_hist.sv | 113 +++++++++++
 tb/tb_counter_hist.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared constants and helpers for the counter_hist event counter.
// Revision : 1.0  initial release
// ============================================================================
package counter_pkg;

   // Bound behaviour selectors for the SATURATE parameter
   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   // Width of the history-stage select; at least one bit, even for DEPTH=1
   function automatic int sel_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hist_shreg.sv
`default_nettype none
// ============================================================================
// Module   : hist_shreg
// Purpose  : Shift-enabled snapshot history with a saturating fill counter.
//            Stage 0 holds the newest snapshot; the oldest drops off the end.
// Revision : 1.0  initial release
// ============================================================================
module hist_shreg
   import counter_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               shift,
   input  logic [WIDTH-1:0]                   din,
   output logic [DEPTH-1:0][WIDTH-1:0]        hist,
   output logic [$clog2(DEPTH+1)-1:0]         fill
);

   localparam int FILLW = $clog2(DEPTH+1);

   // Newest stage captures the incoming snapshot on every shift
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist[0] <= '0;
      end else if (shift) begin
         hist[0] <= din;
      end
   end

   // Older stages take the value of their younger neighbour
   generate
      for (genvar i = 1; i < DEPTH; i++) begin : g_stage
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               hist[i] <= '0;
            end else if (shift) begin
               hist[i] <= hist[i-1];
            end
         end
      end
   endgenerate

   // Count valid stages, saturating once the whole history is populated
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill <= '0;
      end else if (shift && (fill != FILLW'(DEPTH))) begin
         fill <= fill + FILLW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/counter_hist.sv
`default_nettype none
// ============================================================================
// Module   : counter_hist
// Purpose  : Up/down event counter with wrap or saturate bounds, an idle-cycle
//            snapshot history and rollback from a selectable history stage.
//            Output `counter` is the registered count gated by `hout`.
// Revision : 1.0  initial release
// ============================================================================
module counter_hist
   import counter_pkg::*;
#(
   parameter int WIDTH    = 7,
   parameter int DEPTH    = 4,
   parameter int SATURATE = CNT_WRAP
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cp,
   input  logic                           cd,
   input  logic                           pl,
   input  logic [sel_width(DEPTH)-1:0]    pl_sel,
   input  logic                           hout,
   output logic [WIDTH-1:0]               counter,
   output logic [WIDTH-1:0]               count_raw,
   output logic [$clog2(DEPTH+1)-1:0]     hist_fill,
   output logic                           ovf,
   output logic                           pl_err
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [DEPTH-1:0][WIDTH-1:0] hist;
   logic                        shift;
   logic [WIDTH-1:0]            count_nxt;
   logic [WIDTH-1:0]            sel_val;
   logic [WIDTH-1:0]            old_val;
   logic                        ovf_nxt;
   logic                        pl_err_nxt;

   // A cycle is idle only when no request at all is present; cp&cd counts as active
   assign shift = !pl && !cp && !cd;

   hist_shreg #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_hist (
      .clk   (clk),
      .reset (reset),
      .shift (shift),
      .din   (count_raw),
      .hist  (hist),
      .fill  (hist_fill)
   );

   // Next count: rollback beats counting; bounds either wrap or hold
   always_comb begin
      count_nxt  = count_raw;
      ovf_nxt    = (SATURATE == CNT_SAT) ? ovf : 1'b0;
      pl_err_nxt = 1'b0;
      sel_val    = '0;
      old_val    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i == int'(pl_sel))
            sel_val = hist[i];
         if (i == int'(hist_fill) - 1)
            old_val = hist[i];
      end

      if (pl) begin
         ovf_nxt = 1'b0;
         if (int'(pl_sel) < int'(hist_fill)) begin
            count_nxt = sel_val;
         end else begin
            // Out-of-range request falls back to the oldest valid stage, or 0 when empty
            pl_err_nxt = 1'b1;
            count_nxt  = (hist_fill != '0) ? old_val : '0;
         end
      end else if (cp && !cd) begin
         if (count_raw == CNT_MAX) begin
            ovf_nxt = 1'b1;
            if (SATURATE != CNT_SAT)
               count_nxt = '0;
         end else begin
            count_nxt = count_raw + WIDTH'(1);
         end
      end else if (cd && !cp) begin
         if (count_raw == '0) begin
            ovf_nxt = 1'b1;
            if (SATURATE != CNT_SAT)
               count_nxt = CNT_MAX;
         end else begin
            count_nxt = count_raw - WIDTH'(1);
         end
      end
   end

   // Count, overflow and rollback-error registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_raw <= '0;
         ovf       <= 1'b0;
         pl_err    <= 1'b0;
      end else begin
         count_raw <= count_nxt;
         ovf       <= ovf_nxt;
         pl_err    <= pl_err_nxt;
      end
   end

   assign counter = hout ? count_raw : '0;

endmodule
`default_nettype wire

// File: tb/tb_counter_hist.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_hist
// Purpose  : Self-checking bench for counter_hist; a wrap-mode and a
//            saturate-mode instance share stimulus and are compared against
//            an arithmetic reference model every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_counter_hist;

   localparam int WIDTH = 7;
   localparam int DEPTH = 4;
   localparam int SELW  = 2;
   localparam int FILLW = 3;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic             clk    = 1'b0;
   logic             reset  = 1'b1;
   logic             cp     = 1'b0;
   logic             cd     = 1'b0;
   logic             pl     = 1'b0;
   logic [SELW-1:0]  pl_sel = '0;
   logic             hout   = 1'b0;

   logic [WIDTH-1:0] wrap_counter, wrap_count_raw, sat_counter, sat_count_raw;
   logic [FILLW-1:0] wrap_fill, sat_fill;
   logic             wrap_ovf, wrap_pl_err, sat_ovf, sat_pl_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, index 0 = wrap instance, 1 = saturate instance
   int m_count [2];
   int m_fill  [2];
   int m_ovf   [2];
   int m_err   [2];
   int m_hist  [2][DEPTH];

   typedef struct {
      bit cp;
      bit cd;
      bit pl;
      int sel;
      bit hout;
      int exp_count;
      int exp_fill;
      bit exp_err;
   } vec_t;

   vec_t vecs [14];

   counter_hist #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SATURATE(0)) u_wrap (
      .clk       (clk),
      .reset     (reset),
      .cp        (cp),
      .cd        (cd),
      .pl        (pl),
      .pl_sel    (pl_sel),
      .hout      (hout),
      .counter   (wrap_counter),
      .count_raw (wrap_count_raw),
      .hist_fill (wrap_fill),
      .ovf       (wrap_ovf),
      .pl_err    (wrap_pl_err)
   );

   counter_hist #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SATURATE(1)) u_sat (
      .clk       (clk),
      .reset     (reset),
      .cp        (cp),
      .cd        (cd),
      .pl        (pl),
      .pl_sel    (pl_sel),
      .hout      (hout),
      .counter   (sat_counter),
      .count_raw (sat_count_raw),
      .hist_fill (sat_fill),
      .ovf       (sat_ovf),
      .pl_err    (sat_pl_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_count[m] = 0;
         m_fill[m]  = 0;
         m_ovf[m]   = 0;
         m_err[m]   = 0;
         for (int i = 0; i < DEPTH; i++) m_hist[m][i] = 0;
      end
   endtask

   // One clock edge of behaviour, straight from the rules of operation
   task automatic model_step(input bit a_cp, input bit a_cd, input bit a_pl, input int a_sel);
      for (int m = 0; m < 2; m++) begin
         int n;
         m_err[m] = 0;
         if (a_pl) begin
            m_ovf[m] = 0;
            if (a_sel < m_fill[m]) begin
               m_count[m] = m_hist[m][a_sel];
            end else begin
               m_err[m]   = 1;
               m_count[m] = (m_fill[m] > 0) ? m_hist[m][m_fill[m]-1] : 0;
            end
         end else if (a_cp != a_cd) begin
            n = m_count[m] + (a_cp ? 1 : -1);
            if (n < 0 || n > MAXV) begin
               m_ovf[m] = 1;
               if (m == 0) m_count[m] = (n + MAXV + 1) % (MAXV + 1);
            end else begin
               m_count[m] = n;
               if (m == 0) m_ovf[m] = 0;
            end
         end else begin
            if (m == 0) m_ovf[m] = 0;
            if (!a_cp) begin
               for (int i = DEPTH - 1; i > 0; i--) m_hist[m][i] = m_hist[m][i-1];
               m_hist[m][0] = m_count[m];
               if (m_fill[m] < DEPTH) m_fill[m]++;
            end
         end
      end
   endtask

   task automatic compare_all();
      int gate;
      gate = hout ? 1 : 0;
      check("wrap.count_raw", int'(wrap_count_raw), m_count[0]);
      check("wrap.counter",   int'(wrap_counter),   gate * m_count[0]);
      check("wrap.hist_fill", int'(wrap_fill),      m_fill[0]);
      check("wrap.ovf",       int'(wrap_ovf),       m_ovf[0]);
      check("wrap.pl_err",    int'(wrap_pl_err),    m_err[0]);
      check("sat.count_raw",  int'(sat_count_raw),  m_count[1]);
      check("sat.counter",    int'(sat_counter),    gate * m_count[1]);
      check("sat.hist_fill",  int'(sat_fill),       m_fill[1]);
      check("sat.ovf",        int'(sat_ovf),        m_ovf[1]);
      check("sat.pl_err",     int'(sat_pl_err),     m_err[1]);
   endtask

   // Drive one request, let one edge pass, then compare just after the edge
   task automatic cycle(input bit a_cp, input bit a_cd, input bit a_pl, input int a_sel, input bit a_hout);
      cp     = a_cp;
      cd     = a_cd;
      pl     = a_pl;
      pl_sel = SELW'(a_sel);
      hout   = a_hout;
      @(posedge clk);
      model_step(a_cp, a_cd, a_pl, a_sel);
      #1;
      compare_all();
   endtask

   task automatic apply_reset();
      cp    = 1'b0;
      cd    = 1'b0;
      pl    = 1'b0;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no completion, expected $finish before time limit");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Rollback / out-of-range rollback sequence from reset: {cp,cd,pl,sel,hout, count,fill,err}
      vecs[0]  = '{0, 0, 1, 0, 1, 0, 0, 1};  // pl with empty history -> 0, error
      vecs[1]  = '{1, 0, 0, 0, 1, 1, 0, 0};
      vecs[2]  = '{1, 0, 0, 0, 0, 2, 0, 0};
      vecs[3]  = '{1, 0, 0, 0, 1, 3, 0, 0};
      vecs[4]  = '{0, 0, 0, 0, 1, 3, 1, 0};  // snapshot 3
      vecs[5]  = '{1, 0, 0, 0, 1, 4, 1, 0};
      vecs[6]  = '{1, 0, 0, 0, 1, 5, 1, 0};
      vecs[7]  = '{0, 0, 0, 0, 1, 5, 2, 0};  // hist = {5,3}
      vecs[8]  = '{0, 0, 1, 1, 1, 3, 2, 0};  // rollback to stage 1
      vecs[9]  = '{0, 0, 1, 3, 1, 3, 2, 1};  // out of range -> oldest valid
      vecs[10] = '{1, 1, 0, 0, 1, 3, 2, 0};  // cp&cd: no change, no shift
      vecs[11] = '{0, 0, 1, 0, 1, 5, 2, 0};
      vecs[12] = '{0, 0, 0, 0, 0, 5, 3, 0};  // hist = {5,5,3}
      vecs[13] = '{0, 0, 1, 2, 1, 3, 3, 0};

      apply_reset();
      for (int i = 0; i < 14; i++) begin
         cycle(vecs[i].cp, vecs[i].cd, vecs[i].pl, vecs[i].sel, vecs[i].hout);
         check($sformatf("vec%0d.count", i),   int'(wrap_count_raw), vecs[i].exp_count);
         check($sformatf("vec%0d.counter", i), int'(wrap_counter),   vecs[i].hout ? vecs[i].exp_count : 0);
         check($sformatf("vec%0d.fill", i),    int'(wrap_fill),      vecs[i].exp_fill);
         check($sformatf("vec%0d.pl_err", i),  int'(wrap_pl_err),    int'(vecs[i].exp_err));
      end

      // Lower bound: wrap goes to max with a one-cycle ovf, saturate holds with sticky ovf
      apply_reset();
      cycle(0, 1, 0, 0, 1);
      check("wrap.dec_at_0", int'(wrap_count_raw), MAXV);
      check("wrap.ovf_dec",  int'(wrap_ovf), 1);
      check("sat.dec_at_0",  int'(sat_count_raw), 0);
      cycle(0, 0, 0, 0, 1);
      check("wrap.ovf_drop", int'(wrap_ovf), 0);
      check("sat.ovf_stick", int'(sat_ovf), 1);
      cycle(1, 0, 0, 0, 1);
      check("wrap.inc_at_max", int'(wrap_count_raw), 0);
      check("wrap.ovf_inc",    int'(wrap_ovf), 1);

      // Upper bound in saturate mode
      apply_reset();
      for (int i = 0; i < MAXV; i++) cycle(1, 0, 0, 0, 1);
      check("sat.reach_max", int'(sat_count_raw), MAXV);
      check("sat.no_ovf_at_max", int'(sat_ovf), 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1);
      check("sat.hold_max", int'(sat_count_raw), MAXV);
      check("sat.ovf_held", int'(sat_ovf), 1);
      cycle(0, 0, 1, 0, 1);
      check("sat.pl_clears_ovf", int'(sat_ovf), 0);

      // Output gating is purely combinational on hout
      apply_reset();
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
      check("gate.counter_off", int'(wrap_counter), 0);
      #2;
      hout = 1'b1;
      #1;
      check("gate.counter_on", int'(wrap_counter), m_count[0]);
      check("gate.sat_on",     int'(sat_counter),  m_count[1]);

      // Asynchronous reset between edges with count 9 and full history
      apply_reset();
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0, 1);
      check("areset.pre_count", int'(wrap_count_raw), 9);
      check("areset.pre_fill",  int'(wrap_fill), 4);
      #2;
      apply_reset();
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
      check("areset.fill_after", int'(wrap_fill), 4);
      cycle(0, 0, 1, 3, 1);
      check("areset.oldest_zero", int'(wrap_count_raw), 0);

      // Randomised traffic against the model
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         case (r)
            0:       cycle(0, 0, 1, int'($urandom_range(0, 3)), 1'($urandom));
            1, 2:    cycle(0, 0, 0, 0, 1'($urandom));
            3:       cycle(1, 1, 0, 0, 1'($urandom));
            4, 5, 6: cycle(1, 0, 0, 0, 1'($urandom));
            default: cycle(0, 1, 0, 0, 1'($urandom));
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
